// File: rtl/gmem_pkg.sv
// Shared definitions for the global-memory interconnect.
// Holds the default parameter values, the core-id width helper and the
// device-window prefix decode.
package gmem_pkg;

    localparam int DEF_NUM_CORES  = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_GMEM_SIZE  = 1024;
    localparam int DEF_DEV_AW     = 10;
    localparam int DEF_ARB_MODE   = 1;

    localparam int ARB_STATIC = 0;
    localparam int ARB_RR     = 1;

    function automatic int core_id_width(input int num_cores);
        return $clog2(num_cores);
    endfunction

    localparam int CORE_ID_W = core_id_width(DEF_NUM_CORES);

    // An address is in the device window when every bit from dev_aw up to
    // addr_width-1 is set.
    function automatic logic in_dev_window(input logic [31:0] addr,
                                           input int addr_width,
                                           input int dev_aw);
        logic hit;
        hit = 1'b1;
        for (int b = 0; b < 32; b++) begin
            if (b >= dev_aw && b < addr_width && !addr[b]) hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator for the shared memory port.
// ARB_MODE 0: grant rotates one core left every cycle.
// ARB_MODE 1: grant moves to the first requester after the current owner in
//             circular order; the owner keeps it only when nobody else asks.
// Ports: clk, reset (async active-low), req[NUM_CORES], grant[NUM_CORES].
module rr_arbiter
    import gmem_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ARB_MODE  = DEF_ARB_MODE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] grant
);

    logic [NUM_CORES-1:0] grant_q;
    logic [NUM_CORES-1:0] grant_d;
    int                   cur;
    int                   nxt;
    logic                 found;

    // NOTE: every variable assigned in always_comb gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cur     = 0;
        nxt     = 0;
        found   = 1'b0;
        grant_d = grant_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_q[i]) cur = i;
        end
        if (ARB_MODE == ARB_STATIC) begin
            grant_d = {grant_q[NUM_CORES-2:0], grant_q[NUM_CORES-1]};
        end else begin
            // Search starts just after the owner and ends on the owner itself,
            // which is what lets a lone requester keep the grant.
            for (int k = 1; k <= NUM_CORES; k++) begin
                nxt = (cur + k) % NUM_CORES;
                if (!found && req[nxt]) begin
                    grant_d      = '0;
                    grant_d[nxt] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) grant_q <= NUM_CORES'(1);
        else        grant_q <= grant_d;
    end

    assign grant = grant_q;

endmodule

// File: rtl/spsram.sv
// Single-port synchronous RAM, read-first: a read in the same cycle as a
// write to the same word returns the previous contents.
// Ports: clk, we, addr[AW], wdata[DW], rdata[DW] (registered).
module spsram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents survive reset and clearing them
    // would block mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/gmem_interconnect.sv
// Shares one global memory and one device port among NUM_CORES cores.
// The granted core's request is muxed onto the memory and device ports in the
// same cycle; read data returns one cycle later on the broadcast read_val with
// a one-hot read_valid naming the receiving core.
// Ports: clk, reset (async active-low); per-core req_wren/req_rden/req_addr/
// req_write_val; grant, read_val, read_valid; device_core_id, device_write_en,
// device_read_en, device_addr, device_data_out, device_data_in.
module gmem_interconnect
    import gmem_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int GMEM_SIZE  = DEF_GMEM_SIZE,
    parameter int DEV_AW     = DEF_DEV_AW,
    parameter int ARB_MODE   = DEF_ARB_MODE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             req_wren,
    input  logic [NUM_CORES-1:0]             req_rden,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  req_write_val,
    output logic [NUM_CORES-1:0]             grant,
    output logic [DATA_WIDTH-1:0]            read_val,
    output logic [NUM_CORES-1:0]             read_valid,
    output logic [$clog2(NUM_CORES)-1:0]     device_core_id,
    output logic                             device_write_en,
    output logic                             device_read_en,
    output logic [DEV_AW-1:0]                device_addr,
    output logic [DATA_WIDTH-1:0]            device_data_out,
    input  logic [DATA_WIDTH-1:0]            device_data_in
);

    localparam int GMEM_AW = $clog2(GMEM_SIZE);
    localparam int CORE_IW = core_id_width(NUM_CORES);

    logic [CORE_IW-1:0]    g_id;
    logic                  g_wren;
    logic                  g_rden;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  dev_sel;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rd_valid_q;
    logic [CORE_IW-1:0]    rd_id_q;
    logic                  dev_sel_q;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .ARB_MODE  (ARB_MODE)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_wren | req_rden),
        .grant (grant)
    );

    // Grant is one-hot, so selecting on each bit yields the owner's request.
    always_comb begin
        g_id    = '0;
        g_wren  = 1'b0;
        g_rden  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                g_id    = CORE_IW'(i);
                g_wren  = req_wren[i];
                g_rden  = req_rden[i];
                g_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata = req_write_val[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign dev_sel         = in_dev_window(32'(g_addr), ADDR_WIDTH, DEV_AW);
    assign device_core_id  = g_id;
    assign device_write_en = dev_sel & g_wren;
    assign device_read_en  = dev_sel & g_rden;
    assign device_addr     = g_addr[DEV_AW-1:0];
    assign device_data_out = g_wdata;

    // Device-window writes never reach global memory even though their low
    // address bits alias a memory word.
    spsram #(
        .DEPTH (GMEM_SIZE),
        .DW    (DATA_WIDTH),
        .AW    (GMEM_AW)
    ) u_gmem (
        .clk   (clk),
        .we    (g_wren & ~dev_sel),
        .addr  (g_addr[GMEM_AW-1:0]),
        .wdata (g_wdata),
        .rdata (mem_rdata)
    );

    // Remember who read and from where, so the return cycle can steer the
    // right source onto read_val and flag the right core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            dev_sel_q  <= 1'b0;
        end else begin
            rd_valid_q <= g_rden;
            rd_id_q    <= g_id;
            dev_sel_q  <= dev_sel & g_rden;
        end
    end

    always_comb begin
        read_valid = '0;
        if (rd_valid_q) read_valid[rd_id_q] = 1'b1;
    end

    assign read_val = dev_sel_q ? device_data_in : mem_rdata;

endmodule
